eth_rxpreambledet: RTL and testbench
====================================

# eth_rxpreambledet

Receive-side preamble/SFD stripper between the MII/GMII byte interface and `eth_rxethmacdecoder`.

- Watches `MRxDV`/`MRxD` and validates the 0x55 preamble run and the 0xD5 SFD.
- Enforces the inter-frame gap.
- Forwards only the post-SFD frame bytes, as a registered byte stream with start-of-frame and end-of-frame flags and a frame length. The decoder's `RxStartFrm`/`RxEndFrm` inputs are driven from this block.

## Interface
Parameters:
- `MIN_PRE`, default 1: minimum number of 0x55 bytes required before the SFD.
- `MAX_PRE`, default 7: maximum number of 0x55 bytes allowed before the SFD.
- `IFG_BYTES`, default 12: required count of idle (`MRxDV` low) cycles between frames.

Ports:
- `MRxClk`  in  1: receive clock; the block is single-clock.
- `Reset`  in  1: asynchronous, active-high reset.
- `MRxDV`  in  1: PHY receive data valid.
- `MRxD`  in  8: PHY receive byte.
- `r_IFG`  in  1: when 1, the IFG check is disabled and every frame is accepted.
- `RxData`  out  8: frame byte (destination MAC first).
- `RxDataValid`  out  1: `RxData` is valid this cycle.
- `RxStartFrm`  out  1: marks the first frame byte; asserted only together with `RxDataValid`.
- `RxEndFrm`  out  1: marks the last frame byte; asserted only together with `RxDataValid`.
- `FrameLen`  out  16: number of frame bytes; valid in the `RxEndFrm` cycle; saturates at 0xFFFF.
- `PreambleErr`  out  1: one-cycle pulse on a preamble or SFD violation.

## Operation
- **Reset values:**
  - All outputs 0.
  - State `IDLE`.
  - `pre_cnt` 0.
  - `FrameLen` counter 0.
  - Hold register empty.
  - IFG counter preset to `IFG_BYTES`, so the first frame after reset is accepted.
- **IFG counter:**
  - Cleared on every cycle with `MRxDV`=1.
  - Incremented on every cycle with `MRxDV`=0, saturating at `IFG_BYTES`.
  - `ifg_ok = r_IFG | (ifg_cnt == IFG_BYTES)`, evaluated on the counter value before the update.
- **State `IDLE`:**
  - `MRxDV`=0: stay in `IDLE`.
  - `MRxDV`=1, `MRxD`=0x55 and `ifg_ok`: go to `PREAMBLE` with `pre_cnt`=1.
  - `MRxDV`=1 with any other byte, or with `ifg_ok`=0: go to `DROP`; no error pulse.
- **State `PREAMBLE`:**
  - `MRxDV`=0: go to `IDLE` and pulse `PreambleErr`.
  - 0x55 with `pre_cnt` < `MAX_PRE`: stay, `pre_cnt`+1.
  - 0x55 with `pre_cnt` == `MAX_PRE`: go to `DROP` and pulse `PreambleErr`.
  - 0xD5 with `pre_cnt` >= `MIN_PRE`: go to `DATA`, hold register empty, length counter 0.
  - 0xD5 with `pre_cnt` < `MIN_PRE`, or any other byte: go to `DROP` and pulse `PreambleErr`.
- **State `DATA`** (one-byte look-ahead, so the end flag can be attached to the last byte):
  - `MRxDV`=1:
    - If the hold register is full, emit the held byte (`RxDataValid`=1; `RxStartFrm`=1 if it is the first byte of the frame).
    - Load `MRxD` into the hold register.
    - Length counter +1 (saturating).
  - `MRxDV`=0 with the hold register full: emit the held byte with `RxEndFrm`=1 and `FrameLen` = counter; go to `IDLE`.
  - A one-byte frame asserts `RxStartFrm` and `RxEndFrm` in the same cycle.
  - `MRxDV`=0 with the hold register empty (SFD immediately followed by DV low): go to `IDLE`; no output and no error.
- **State `DROP`:** stay until `MRxDV`=0, then go to `IDLE`.
- **Reset mid-frame:** everything clears immediately. If `MRxDV` is still high after reset, the block sees a non-0x55 byte or proceeds through the normal checks, so the remainder of the frame is either dropped or treated as a new preamble.

## Timing
- All outputs are registered. Combinational paths exist only into next-state and next-output logic.
- **Latency:**
  - A non-last frame byte sampled at edge t appears on `RxData` after edge t+1, i.e. 2 cycles from `MRxD` to `RxData`.
  - The last byte appears one cycle after the edge that samples `MRxDV`=0.
- `PreambleErr` is asserted for exactly one cycle, in the cycle after the violating sample.
- `RxDataValid` has no gaps within a frame as long as `MRxDV` stays high (8-bit interface, one byte per clock).
- No backpressure: the downstream block must accept one byte per cycle.

## Structure
- Shared package `eth_rx_pkg` holds:
  - the `rxpre_state_t` enum (`IDLE`, `PREAMBLE`, `DATA`, `DROP`; 2-bit);
  - the constants `ETH_PREAMBLE_BYTE` = 8'h55 and `ETH_SFD_BYTE` = 8'hD5.
- One sub-module, `eth_rxifgcnt`, with ports `MRxClk`, `Reset`, `MRxDV`, `r_IFG`, parameter `IFG_BYTES`, and output `ifg_ok`.
- The rest of the block is a single FSM with the hold register, `pre_cnt`, and the length counter.

## Test plan
- **Standard frame:** 7×0x55, 0xD5, then 64 bytes 0x00..0x3F, then DV low.
  - Required: 64 valid beats, `RxStartFrm` on 0x00, `RxEndFrm` on 0x3F, `FrameLen`=64, no `PreambleErr`.
- **One-byte frame:** 0x55, 0xD5, 0xAB, then DV low.
  - Required: a single beat 0xAB with `RxStartFrm`=`RxEndFrm`=1 and `FrameLen`=1.
- **Preamble violations:**
  - Bad SFD: 0x55×3, 0x5D. Required: `PreambleErr` pulse, no output, rest of the frame dropped until DV low.
  - Over-long preamble: 8×0x55 with `MAX_PRE`=7. Required: `PreambleErr` pulse, frame dropped.
- **IFG enforcement:** back-to-back frames separated by 5 idle cycles.
  - With `r_IFG`=0: the second frame is dropped silently.
  - With `r_IFG`=1: the second frame is received.
  - With 12 idle cycles: the second frame is received regardless of `r_IFG`.
- **Reset mid-frame:** assert `Reset` at data byte 20.
  - Required: all outputs 0 immediately, no `RxEndFrm`.
  - A following well-formed frame is received normally.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared state type and preamble/SFD byte constants for the receive path
package eth_rx_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rxpre_state_t;
    localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;
endpackage

// File: rtl/eth_rxifgcnt.sv
// eth_rxifgcnt: counts idle receive cycles and flags when the inter-frame gap is satisfied
module eth_rxifgcnt #(
    parameter int IFG_BYTES = 12
) (
    input  logic MRxClk,
    input  logic Reset,
    input  logic MRxDV,
    input  logic r_IFG,
    output logic ifg_ok
);
    localparam int W = $clog2(IFG_BYTES + 2);
    localparam logic [W-1:0] MAXC = W'(IFG_BYTES);

    logic [W-1:0] r_cnt;

    // preset to full so the first frame after reset is accepted
    always_ff @(posedge MRxClk or posedge Reset)
        if (Reset)
            r_cnt <= MAXC;
        else if (MRxDV)
            r_cnt <= '0;
        else if (r_cnt != MAXC)
            r_cnt <= r_cnt + 1'b1;

    assign ifg_ok = r_IFG | (r_cnt == MAXC);
endmodule

// File: rtl/eth_rxpreambledet.sv
// eth_rxpreambledet: validates preamble/SFD and IFG, forwards post-SFD bytes with SOF/EOF and length
module eth_rxpreambledet
    import eth_rx_pkg::*;
#(
    parameter int MIN_PRE   = 1,
    parameter int MAX_PRE   = 7,
    parameter int IFG_BYTES = 12
) (
    input  logic        MRxClk,
    input  logic        Reset,
    input  logic        MRxDV,
    input  logic [7:0]  MRxD,
    input  logic        r_IFG,
    output logic [7:0]  RxData,
    output logic        RxDataValid,
    output logic        RxStartFrm,
    output logic        RxEndFrm,
    output logic [15:0] FrameLen,
    output logic        PreambleErr
);
    localparam int PW = $clog2(MAX_PRE + 2);
    localparam logic [PW-1:0] MAXP = PW'(MAX_PRE);
    localparam logic [PW-1:0] MINP = PW'(MIN_PRE);

    rxpre_state_t  r_state, w_state_n;
    logic [PW-1:0] r_pre_cnt, w_pre_n;
    logic [7:0]    r_hold, w_hold_n, w_data_n;
    logic          r_full, w_full_n, r_first, w_first_n;
    logic [15:0]   r_len, w_len_n, w_flen_n;
    logic          w_dv_n, w_sof_n, w_eof_n, w_err_n;
    logic          w_ifg_ok;

    eth_rxifgcnt #(.IFG_BYTES(IFG_BYTES)) u_ifgcnt (
        .MRxClk (MRxClk),
        .Reset  (Reset),
        .MRxDV  (MRxDV),
        .r_IFG  (r_IFG),
        .ifg_ok (w_ifg_ok)
    );

    always_comb begin
        w_state_n = r_state;
        w_pre_n   = r_pre_cnt;
        w_hold_n  = r_hold;
        w_full_n  = r_full;
        w_first_n = r_first;
        w_len_n   = r_len;
        w_data_n  = RxData;
        w_dv_n    = 1'b0;
        w_sof_n   = 1'b0;
        w_eof_n   = 1'b0;
        w_flen_n  = '0;
        w_err_n   = 1'b0;
        case (r_state)
            IDLE: if (MRxDV) begin
                w_state_n = (MRxD == ETH_PREAMBLE_BYTE && w_ifg_ok) ? PREAMBLE : DROP;
                w_pre_n   = PW'(1);
            end
            PREAMBLE: if (!MRxDV) begin
                w_state_n = IDLE;
                w_err_n   = 1'b1;
            end else if (MRxD == ETH_PREAMBLE_BYTE && r_pre_cnt < MAXP) begin
                w_pre_n = r_pre_cnt + 1'b1;
            end else if (MRxD == ETH_SFD_BYTE && r_pre_cnt >= MINP) begin
                w_state_n = DATA;
                w_full_n  = 1'b0;
                w_first_n = 1'b1;
                w_len_n   = '0;
            end else begin
                w_state_n = DROP;
                w_err_n   = 1'b1;
            end
            // one-byte look-ahead: the held byte goes out now, tagged as last if DV just dropped
            DATA: begin
                w_dv_n    = r_full;
                w_sof_n   = r_full & r_first;
                w_eof_n   = r_full & ~MRxDV;
                w_flen_n  = (r_full & ~MRxDV) ? r_len : 16'd0;
                w_data_n  = r_full ? r_hold : RxData;
                w_first_n = r_first & ~r_full;
                if (MRxDV) begin
                    w_hold_n = MRxD;
                    w_full_n = 1'b1;
                    w_len_n  = (&r_len) ? r_len : r_len + 16'd1;
                end else begin
                    w_state_n = IDLE;
                    w_full_n  = 1'b0;
                end
            end
            DROP: if (!MRxDV) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge MRxClk or posedge Reset)
        if (Reset) begin
            r_state     <= IDLE;
            r_pre_cnt   <= '0;
            r_hold      <= '0;
            r_full      <= 1'b0;
            r_first     <= 1'b0;
            r_len       <= '0;
            RxData      <= '0;
            RxDataValid <= 1'b0;
            RxStartFrm  <= 1'b0;
            RxEndFrm    <= 1'b0;
            FrameLen    <= '0;
            PreambleErr <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_pre_cnt   <= w_pre_n;
            r_hold      <= w_hold_n;
            r_full      <= w_full_n;
            r_first     <= w_first_n;
            r_len       <= w_len_n;
            RxData      <= w_data_n;
            RxDataValid <= w_dv_n;
            RxStartFrm  <= w_sof_n;
            RxEndFrm    <= w_eof_n;
            FrameLen    <= w_flen_n;
            PreambleErr <= w_err_n;
        end
endmodule

// File: tb/tb_eth_rxpreambledet.sv
// tb_eth_rxpreambledet: randomized frame stimulus checked against a burst-level reference model
module tb_eth_rxpreambledet;
    localparam int MIN_PRE = 1, MAX_PRE = 7, IFG = 12;

    typedef struct packed {
        logic [7:0]  d;
        logic        s;
        logic        e;
        logic [15:0] l;
        logic [31:0] t;
    } beat_t;

    logic clk = 1'b0, rst = 1'b1, mrxdv = 1'b0, rifg = 1'b0;
    logic [7:0] mrxd = '0;
    logic [7:0] rx_data;
    logic rx_dv, rx_sof, rx_eof, pre_err;
    logic [15:0] flen;

    beat_t obs_q[$], exp_q[$];
    int obs_err[$], exp_err[$];
    logic st_dv[$], st_ifg[$];
    logic [7:0] st_d[$];
    int st_t[$];
    int cyc = 0, stray = 0, checks = 0, errors = 0, m_gap = IFG;

    always #5 clk = ~clk;

    eth_rxpreambledet #(.MIN_PRE(MIN_PRE), .MAX_PRE(MAX_PRE), .IFG_BYTES(IFG)) dut (
        .MRxClk(clk), .Reset(rst), .MRxDV(mrxdv), .MRxD(mrxd), .r_IFG(rifg),
        .RxData(rx_data), .RxDataValid(rx_dv), .RxStartFrm(rx_sof), .RxEndFrm(rx_eof),
        .FrameLen(flen), .PreambleErr(pre_err)
    );

    // cyc numbers the edges; an output seen here was produced by edge cyc
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (rx_dv) obs_q.push_back(beat_t'{rx_data, rx_sof, rx_eof, rx_eof ? flen : 16'd0, 32'(cyc)});
        if ((rx_sof | rx_eof) & ~rx_dv) stray++;
        if (pre_err) obs_err.push_back(cyc);
    end

    task automatic drv(input logic dv, input logic [7:0] d);
        @(negedge clk);
        mrxdv = dv;
        mrxd  = d;
        st_dv.push_back(dv);
        st_d.push_back(d);
        st_ifg.push_back(rifg);
        st_t.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 8'($urandom));
    endtask

    task automatic frame(input int npre, input logic [7:0] sfd, input int plen);
        repeat (npre) drv(1'b1, 8'h55);
        drv(1'b1, sfd);
        repeat (plen) drv(1'b1, 8'($urandom));
    endtask

    task automatic begin_test();
        st_dv.delete(); st_d.delete(); st_ifg.delete(); st_t.delete();
        obs_q.delete(); obs_err.delete();
    endtask

    // Whole DV bursts are judged at once: gap rule, leading 0x55 run, SFD, payload
    task automatic model_run();
        int i = 0;
        int n = st_dv.size();
        int e, k, p;
        exp_q.delete();
        exp_err.delete();
        while (i < n) begin
            if (!st_dv[i]) begin
                if (m_gap < IFG) m_gap++;
                i++;
            end else begin
                e = i;
                k = 0;
                while (e < n && st_dv[e]) e++;
                if ((st_ifg[i] || m_gap == IFG) && st_d[i] == 8'h55) begin
                    p = i;
                    while (p < e && st_d[p] == 8'h55 && k < MAX_PRE) begin k++; p++; end
                    if (p == e) begin
                        if (e < n) exp_err.push_back(st_t[e]);
                    end else if (st_d[p] == 8'hD5 && k >= MIN_PRE) begin
                        for (int q = p + 1; q < e; q++)
                            exp_q.push_back(beat_t'{st_d[q], q == p + 1, q == e - 1,
                                q == e - 1 ? 16'(e - 1 - p) : 16'd0, 32'(st_t[q] + 1)});
                    end else begin
                        exp_err.push_back(st_t[p]);
                    end
                end
                m_gap = 0;
                i = e;
            end
        end
    endtask

    task automatic end_test();
        @(posedge clk);
        #2;
        model_run();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({rx_data, rx_dv, rx_sof, rx_eof, flen, pre_err} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {rx_data, rx_dv, rx_sof, rx_eof, flen, pre_err});
        end
        @(negedge clk) rst = 1'b0;
        m_gap = IFG;
    endtask

    task automatic test_standard_frame();
        begin_test();
        rifg = 1'b0;
        repeat (7) drv(1'b1, 8'h55);
        drv(1'b1, 8'hD5);
        for (int i = 0; i < 64; i++) drv(1'b1, 8'(i));
        idle(14);
        end_test();
        checks++;
        if (obs_q.size() !== 64 || obs_err.size() !== 0) begin
            errors++;
            $display("FAIL std_counts: got beats=%0d errs=%0d want beats=64 errs=0", obs_q.size(), obs_err.size());
        end
        if (obs_q.size() == 64) begin
            checks++;
            if ({obs_q[0].d, obs_q[0].s} !== {8'h00, 1'b1}) begin
                errors++;
                $display("FAIL std_first: got d=%h sof=%b want d=00 sof=1", obs_q[0].d, obs_q[0].s);
            end
            checks++;
            if ({obs_q[63].d, obs_q[63].e, obs_q[63].l} !== {8'h3F, 1'b1, 16'd64}) begin
                errors++;
                $display("FAIL std_last: got d=%h eof=%b len=%0d want d=3f eof=1 len=64", obs_q[63].d, obs_q[63].e, obs_q[63].l);
            end
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL std_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_one_byte();
        begin_test();
        drv(1'b1, 8'h55);
        drv(1'b1, 8'hD5);
        drv(1'b1, 8'hAB);
        idle(14);
        end_test();
        checks++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
            errors++;
            $display("FAIL one_count: got %0d want 1 (model %0d)", obs_q.size(), exp_q.size());
        end else begin
            checks++;
            if ({obs_q[0].d, obs_q[0].s, obs_q[0].e, obs_q[0].l} !== {8'hAB, 1'b1, 1'b1, 16'd1}) begin
                errors++;
                $display("FAIL one_beat: got %h want ab/1/1/1", obs_q[0]);
            end
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL one_time: got %h want %h", obs_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_preamble_errors();
        begin_test();
        frame(3, 8'h5D, 4);
        idle(14);
        frame(8, 8'hD5, 4);
        idle(14);
        end_test();
        checks++;
        if (obs_q.size() !== 0 || obs_err.size() !== 2) begin
            errors++;
            $display("FAIL pre_counts: got beats=%0d errs=%0d want beats=0 errs=2", obs_q.size(), obs_err.size());
        end
        foreach (exp_err[i]) if (i < obs_err.size()) begin
            checks++;
            if (obs_err[i] !== exp_err[i]) begin
                errors++;
                $display("FAIL pre_err%0d: got t=%0d want t=%0d", i, obs_err[i], exp_err[i]);
            end
        end
    endtask

    task automatic test_ifg();
        int gaps[4] = '{5, 5, 12, 12};
        logic ifgs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int want[4] = '{10, 20, 20, 20};
        for (int c = 0; c < 4; c++) begin
            begin_test();
            rifg = ifgs[c];
            frame(7, 8'hD5, 10);
            idle(gaps[c]);
            frame(7, 8'hD5, 10);
            idle(14);
            end_test();
            checks++;
            if (obs_q.size() !== want[c] || obs_err.size() !== 0) begin
                errors++;
                $display("FAIL ifg%0d_counts: got beats=%0d errs=%0d want beats=%0d errs=0", c, obs_q.size(), obs_err.size(), want[c]);
            end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL ifg%0d_beat%0d: got %h want %h", c, i, obs_q[i], exp_q[i]);
                end
            end
        end
        rifg = 1'b0;
    endtask

    task automatic test_truncated();
        begin_test();
        drv(1'b1, 8'h55);
        drv(1'b1, 8'hD5);
        idle(14);
        drv(1'b1, 8'h55);
        drv(1'b1, 8'h55);
        idle(14);
        end_test();
        checks++;
        if (obs_q.size() !== 0 || obs_err.size() !== 1) begin
            errors++;
            $display("FAIL trunc_counts: got beats=%0d errs=%0d want beats=0 errs=1", obs_q.size(), obs_err.size());
        end
        if (obs_err.size() == 1 && exp_err.size() == 1) begin
            checks++;
            if (obs_err[0] !== exp_err[0]) begin
                errors++;
                $display("FAIL trunc_err: got t=%0d want t=%0d", obs_err[0], exp_err[0]);
            end
        end
    endtask

    task automatic test_random();
        begin_test();
        stray = 0;
        for (int f = 0; f < 40; f++) begin
            rifg = 1'($urandom);
            idle($urandom_range(1, 15));
            frame($urandom_range(0, 9), ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hD5, $urandom_range(0, 20));
        end
        idle(14);
        end_test();
        rifg = 1'b0;
        checks++;
        if (obs_q.size() !== exp_q.size() || obs_err.size() !== exp_err.size() || stray !== 0) begin
            errors++;
            $display("FAIL rnd_counts: got beats=%0d errs=%0d stray=%0d want beats=%0d errs=%0d stray=0",
                     obs_q.size(), obs_err.size(), stray, exp_q.size(), exp_err.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rnd_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        foreach (exp_err[i]) if (i < obs_err.size()) begin
            checks++;
            if (obs_err[i] !== exp_err[i]) begin
                errors++;
                $display("FAIL rnd_err%0d: got t=%0d want t=%0d", i, obs_err[i], exp_err[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int eofs = 0;
        begin_test();
        frame(7, 8'hD5, 20);
        @(negedge clk);
        mrxdv = 1'b1;
        mrxd  = 8'($urandom);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rx_data, rx_dv, rx_sof, rx_eof, flen, pre_err} !== 28'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h want 0", {rx_data, rx_dv, rx_sof, rx_eof, flen, pre_err});
        end
        foreach (obs_q[i]) eofs += obs_q[i].e;
        checks++;
        if (obs_q.size() !== 19 || eofs !== 0) begin
            errors++;
            $display("FAIL rstmid_partial: got beats=%0d eofs=%0d want beats=19 eofs=0", obs_q.size(), eofs);
        end
        for (int i = 0; i < 19 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].d !== st_d[8 + i]) begin
                errors++;
                $display("FAIL rstmid_data%0d: got %h want %h", i, obs_q[i].d, st_d[8 + i]);
            end
        end
        begin_test();
        m_gap = IFG;
        @(negedge clk) rst = 1'b0;
        repeat (5) drv(1'b1, 8'($urandom_range(0, 8'h54)));
        idle(14);
        frame(7, 8'hD5, 16);
        idle(14);
        end_test();
        checks++;
        if (obs_q.size() !== 16 || exp_q.size() !== 16 || obs_err.size() !== 0) begin
            errors++;
            $display("FAIL rstmid_next: got beats=%0d errs=%0d want beats=16 errs=0 (model %0d)", obs_q.size(), obs_err.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rstmid_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_standard_frame();
        test_one_byte();
        test_preamble_errors();
        test_ifg();
        test_truncated();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
